// File: rtl/game_pkg.sv
// Definitions shared by the game datapath and the game state machine:
// state encodings and BCD helpers for the two-digit score and time counters.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOSE = 2'b11
   } game_state_t;

   localparam int BCD_W = 8;

   function automatic logic [BCD_W-1:0] to_bcd8(input int value);
      int tens;
      int ones;
      tens = value / 10;
      ones = value % 10;
      to_bcd8 = {tens[3:0], ones[3:0]};
   endfunction

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = value[7:4];
      ones = value[3:0];
      if (ones >= 4'd9) begin
         ones = 4'd0;
         tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
         ones = ones + 4'd1;
      end
      bcd_inc = {tens, ones};
   endfunction

   // Saturates at 00 so a stray decrement can never produce a non-BCD digit.
   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = value[7:4];
      ones = value[3:0];
      if (value == 8'h00) begin
         tens = 4'd0;
         ones = 4'd0;
      end else if (ones == 4'd0) begin
         ones = 4'd9;
         tens = tens - 4'd1;
      end else begin
         ones = ones - 4'd1;
      end
      bcd_dec = {tens, ones};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-second divider: one-cycle tick every TICK_DIV enabled cycles,
// counter held at zero while disabled so each game starts a fresh second.
module tick_gen
   import game_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             last_s;

   assign last_s = (cnt_r == LAST);

   // Divider counter: wraps at LAST, cleared whenever the game is not running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (!en) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (last_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign tick = en & last_s;

endmodule

// File: rtl/score_timer.sv
// Score and countdown datapath feeding the game state machine: counts hits and
// game seconds in BCD and flags target reached (Ts) and time up (Tt).
module score_timer
   import game_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int GAME_SEC = 30,
   parameter int TARGET   = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] state,
   input  logic       hit_key,
   output logic [7:0] score_bcd,
   output logic [7:0] time_bcd,
   output logic       Ts,
   output logic       Tt
);

   localparam logic [BCD_W-1:0] GAME_BCD   = to_bcd8(GAME_SEC);
   localparam logic [BCD_W-1:0] TARGET_BCD = to_bcd8(TARGET);

   game_state_t      state_s;
   logic             play_s;
   logic             sync1_r;
   logic             sync2_r;
   logic             sync3_r;
   logic             hit_pulse_s;
   logic             tick_s;
   logic             ts_s;
   logic             tt_s;
   logic [BCD_W-1:0] score_r;
   logic [BCD_W-1:0] score_nxt_s;
   logic [BCD_W-1:0] time_r;
   logic [BCD_W-1:0] time_nxt_s;

   assign state_s = game_state_t'(state);
   assign play_s  = (state_s == ST_PLAY);

   // Hit synchronizer plus one delay stage for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= hit_key;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign hit_pulse_s = sync2_r & ~sync3_r;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (play_s),
      .tick  (tick_s)
   );

   // BCD compare is numeric as long as both digits stay in 0..9.
   assign ts_s = (score_r >= TARGET_BCD);
   assign tt_s = (time_r == 8'h00);

   // Score next-state: cleared in IDLE, counts accepted hits in PLAY, holds otherwise.
   always_comb begin
      score_nxt_s = score_r;
      case (state_s)
         ST_IDLE: score_nxt_s = 8'h00;
         ST_PLAY: begin
            if (hit_pulse_s && !ts_s && !tt_s) begin
               score_nxt_s = bcd_inc(score_r);
            end else begin
               score_nxt_s = score_r;
            end
         end
         default: score_nxt_s = score_r;
      endcase
   end

   // Time next-state: reloaded in IDLE, counts down on ticks in PLAY until won or expired.
   always_comb begin
      time_nxt_s = time_r;
      case (state_s)
         ST_IDLE: time_nxt_s = GAME_BCD;
         ST_PLAY: begin
            if (tick_s && !tt_s && !ts_s) begin
               time_nxt_s = bcd_dec(time_r);
            end else begin
               time_nxt_s = time_r;
            end
         end
         default: time_nxt_s = time_r;
      endcase
   end

   // Score and time registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_r <= 8'h00;
         time_r  <= GAME_BCD;
      end else begin
         score_r <= score_nxt_s;
         time_r  <= time_nxt_s;
      end
   end

   assign score_bcd = score_r;
   assign time_bcd  = time_r;
   assign Ts        = ts_s;
   assign Tt        = tt_s;

endmodule

// File: tb/tb_score_timer.sv
// Directed bench for score_timer: main instance (TICK_DIV=4, GAME_SEC=5, TARGET=3)
// and a second instance (GAME_SEC=20, TARGET=12) for multi-digit BCD carries.
module tb_score_timer;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] state;
   logic       hit_key;
   logic [7:0] score_bcd;
   logic [7:0] time_bcd;
   logic       Ts;
   logic       Tt;

   logic [1:0] state_b;
   logic       hit_b;
   logic [7:0] score_b;
   logic [7:0] time_b;
   logic       ts_b;
   logic       tt_b;

   typedef struct {
      logic [7:0] score;
      logic [7:0] tim;
      logic       ts;
      logic       tt;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   score_timer #(
      .TICK_DIV (4),
      .GAME_SEC (5),
      .TARGET   (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .hit_key   (hit_key),
      .score_bcd (score_bcd),
      .time_bcd  (time_bcd),
      .Ts        (Ts),
      .Tt        (Tt)
   );

   score_timer #(
      .TICK_DIV (4),
      .GAME_SEC (20),
      .TARGET   (12)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_b),
      .hit_key   (hit_b),
      .score_bcd (score_b),
      .time_bcd  (time_b),
      .Ts        (ts_b),
      .Tt        (tt_b)
   );

   function automatic logic [7:0] bcd(input int v);
      bcd = 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int sc, input int tm, input logic ts, input logic tt);
      exp_t e;
      e.score = bcd(sc);
      e.tim   = bcd(tm);
      e.ts    = ts;
      e.tt    = tt;
      sb_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare(input string tag, input logic [7:0] sc, input logic [7:0] tm,
                          input logic ts, input logic tt);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed output with empty scoreboard, expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".score"}, sc, e.score);
         chk({tag, ".time"}, tm, e.tim);
         chk({tag, ".Ts"}, {7'd0, ts}, {7'd0, e.ts});
         chk({tag, ".Tt"}, {7'd0, tt}, {7'd0, e.tt});
      end
   endtask

   task automatic pop_a(input string tag);
      compare(tag, score_bcd, time_bcd, Ts, Tt);
   endtask

   task automatic pop_b(input string tag);
      compare(tag, score_b, time_b, ts_b, tt_b);
   endtask

   initial begin
      rst_n   = 1'b0;
      state   = ST_IDLE;
      hit_key = 1'b0;
      state_b = ST_IDLE;
      hit_b   = 1'b0;
      step(3);

      // Reset and IDLE values.
      rst_n = 1'b1;
      expect_out(0, 5, 1'b0, 1'b0);
      expect_out(0, 20, 1'b0, 1'b0);
      step(2);
      pop_a("reset");
      pop_b("reset_b");

      // Hits 10 cycles apart; WIN between windows freezes the clock so all fit.
      for (int i = 1; i <= 4; i++) begin
         state   = ST_PLAY;
         hit_key = 1'b1;
         expect_out((i > 3) ? 3 : i - 1, 5, (i > 3), 1'b0);
         step(2);
         pop_a("hit_pre");
         expect_out((i > 3) ? 3 : i, 5, (i >= 3), 1'b0);
         step(1);
         pop_a("hit");
         hit_key = 1'b0;
         state   = ST_WIN;
         step(7);
      end
      state = ST_IDLE;
      expect_out(0, 5, 1'b0, 1'b0);
      step(1);
      pop_a("idle_clear");

      // Countdown with no hits: one step per 4 cycles, Tt at cycle 20.
      state = ST_PLAY;
      for (int k = 1; k <= 5; k++) begin
         expect_out(0, 6 - k, 1'b0, 1'b0);
         step(3);
         pop_a("tick_pre");
         expect_out(0, 5 - k, 1'b0, (k == 5));
         step(1);
         pop_a("tick");
      end
      expect_out(0, 0, 1'b0, 1'b1);
      step(8);
      pop_a("time_hold");
      state = ST_IDLE;
      expect_out(0, 5, 1'b0, 1'b0);
      step(1);
      pop_a("time_reload");

      // Key held for 30 cycles counts once.
      state   = ST_PLAY;
      hit_key = 1'b1;
      expect_out(1, 5, 1'b0, 1'b0);
      step(3);
      pop_a("held_first");
      expect_out(1, 0, 1'b0, 1'b1);
      step(27);
      pop_a("held_30");
      hit_key = 1'b0;
      state   = ST_IDLE;
      expect_out(0, 5, 1'b0, 1'b0);
      step(3);
      pop_a("held_idle");

      // Third hit lands on the final tick: both take effect together.
      state   = ST_PLAY;
      hit_key = 1'b1;
      expect_out(1, 5, 1'b0, 1'b0);
      step(3);
      pop_a("align_h1");
      hit_key = 1'b0;
      step(5);
      hit_key = 1'b1;
      expect_out(2, 3, 1'b0, 1'b0);
      step(3);
      pop_a("align_h2");
      hit_key = 1'b0;
      step(6);
      hit_key = 1'b1;
      expect_out(2, 1, 1'b0, 1'b0);
      step(2);
      pop_a("align_pre");
      expect_out(3, 0, 1'b1, 1'b1);
      step(1);
      pop_a("align_final");
      hit_key = 1'b0;
      state   = ST_IDLE;
      expect_out(0, 5, 1'b0, 1'b0);
      step(3);
      pop_a("align_idle");

      // Asynchronous reset mid-game at score 02, time 03.
      state   = ST_PLAY;
      hit_key = 1'b1;
      step(3);
      hit_key = 1'b0;
      step(5);
      hit_key = 1'b1;
      expect_out(2, 3, 1'b0, 1'b0);
      step(3);
      pop_a("rst_setup");
      hit_key = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(0, 5, 1'b0, 1'b0);
      pop_a("async_reset");
      state = ST_IDLE;
      step(1);
      rst_n = 1'b1;
      expect_out(0, 5, 1'b0, 1'b0);
      step(2);
      pop_a("after_reset");

      // Second instance: score carries 09->10, time borrows 20->19, saturates at 12.
      state_b = ST_PLAY;
      for (int i = 1; i <= 12; i++) begin
         hit_b = 1'b1;
         expect_out(i, (i < 12) ? 20 - i : 9, (i >= 12), 1'b0);
         step(2);
         hit_b = 1'b0;
         step(2);
         pop_b("bcd_b");
      end
      hit_b = 1'b1;
      expect_out(12, 9, 1'b1, 1'b0);
      step(2);
      hit_b = 1'b0;
      step(2);
      pop_b("bcd_b_sat");
      state_b = ST_IDLE;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
